// File: rtl/decode_stage_if.sv
// Fetch/decode/execute/writeback signal bundle for the instruction decode stage.
// The slave modport is the decode stage's own view; master is the surrounding pipeline.
interface decode_stage_if #(
    parameter int unsigned PC_W = 16
);
    logic            flush;
    logic            if_valid;
    logic [15:0]     if_ir;
    logic [PC_W-1:0] if_pc;
    logic            if_ready;
    logic            ex_ready;
    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic [3:0]      id_op;
    logic [2:0]      id_rd;
    logic [2:0]      id_rs1;
    logic [2:0]      id_rs2;
    logic [15:0]     id_imm;
    logic            id_we;
    logic            id_illegal;
    logic            wb_valid;
    logic [2:0]      wb_rd;
    logic            halt_program;

    modport master (
        output flush, if_valid, if_ir, if_pc, ex_ready, wb_valid, wb_rd,
        input  if_ready, id_valid, id_pc, id_op, id_rd, id_rs1, id_rs2,
               id_imm, id_we, id_illegal, halt_program
    );

    modport slave (
        input  flush, if_valid, if_ir, if_pc, ex_ready, wb_valid, wb_rd,
        output if_ready, id_valid, id_pc, id_op, id_rd, id_rs1, id_rs2,
               id_imm, id_we, id_illegal, halt_program
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: field decode, immediate sign-extension, register
// scoreboard with RAW stall, and a single-entry output register toward execute.
module decode_stage #(
    parameter int unsigned PC_W  = 16,
    parameter bit          SB_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int unsigned NREG = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [3:0]  op_f;
    logic [2:0]  rd_f, rs1_f, rs2_f;
    logic [15:0] imm6_sx, imm12_sx;

    logic [3:0]  dec_op;
    logic [2:0]  dec_rd, dec_rs1, dec_rs2;
    logic [15:0] dec_imm;
    logic        dec_we, dec_ill;

    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      op_q, op_d;
    logic [2:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [15:0]     imm_q, imm_d;
    logic            we_q, we_d, ill_q, ill_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            halt_q, halt_d;

    logic            halt_pending, issue, hazard, ready, accept;
    logic [NREG-1:0] clr_mask, set_mask, busy_view;

    assign op_f     = bus.if_ir[15:12];
    assign rd_f     = bus.if_ir[11:9];
    assign rs1_f    = bus.if_ir[8:6];
    assign rs2_f    = bus.if_ir[5:3];
    assign imm6_sx  = {{10{bus.if_ir[5]}}, bus.if_ir[5:0]};
    assign imm12_sx = {{4{bus.if_ir[11]}}, bus.if_ir[11:0]};

    // Field decode; sources not read by an opcode are reported as r0.
    always_comb begin
        dec_op  = OP_NOP;
        dec_rd  = 3'd0;
        dec_rs1 = 3'd0;
        dec_rs2 = 3'd0;
        dec_imm = 16'd0;
        dec_we  = 1'b0;
        dec_ill = 1'b0;
        case (op_f)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                dec_op  = op_f;
                dec_rd  = rd_f;
                dec_rs1 = rs1_f;
                dec_rs2 = rs2_f;
                dec_we  = (rd_f != 3'd0);
            end
            OP_ADDI, OP_LD: begin
                dec_op  = op_f;
                dec_rd  = rd_f;
                dec_rs1 = rs1_f;
                dec_imm = imm6_sx;
                dec_we  = (rd_f != 3'd0);
            end
            OP_ST, OP_BEQ: begin
                dec_op  = op_f;
                dec_rs1 = rs1_f;
                dec_rs2 = rd_f;
                dec_imm = imm6_sx;
            end
            OP_JMP: begin
                dec_op  = op_f;
                dec_imm = imm12_sx;
            end
            OP_HALT: dec_op = op_f;
            default: dec_ill = 1'b1;
        endcase
    end

    function automatic logic src_busy(input logic [2:0] s, input logic [NREG-1:0] bv,
                                      input logic hold_we, input logic [2:0] hold_rd);
        return (s != 3'd0) && (bv[s] || (hold_we && hold_rd == s));
    endfunction

    assign halt_pending = valid_q && (op_q == OP_HALT);
    assign issue        = valid_q && bus.ex_ready && !bus.flush;
    assign clr_mask     = bus.wb_valid ? (NREG'(1) << bus.wb_rd) : '0;
    assign set_mask     = (issue && we_q) ? (NREG'(1) << rd_q) : '0;
    // Same-cycle writeback bypass; an issuing writer of the same register is caught by the held-rd term.
    assign busy_view    = busy_q & ~clr_mask;
    assign hazard       = SB_EN &&
                          (src_busy(dec_rs1, busy_view, valid_q && we_q, rd_q) ||
                           src_busy(dec_rs2, busy_view, valid_q && we_q, rd_q));
    assign ready        = !rst && !bus.flush && !halt_pending && !halt_q && !hazard &&
                          (!valid_q || bus.ex_ready);
    assign accept       = bus.if_valid && ready;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        we_d    = we_q;
        ill_d   = ill_q;
        busy_d  = ((busy_q & ~clr_mask) | set_mask) & ~NREG'(1);
        halt_d  = halt_q || (issue && op_q == OP_HALT);
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pc_d    = bus.if_pc;
            op_d    = dec_op;
            rd_d    = dec_rd;
            rs1_d   = dec_rs1;
            rs2_d   = dec_rs2;
            imm_d   = dec_imm;
            we_d    = dec_we;
            ill_d   = dec_ill;
        end else if (valid_q && bus.ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            op_q    <= 4'd0;
            rd_q    <= 3'd0;
            rs1_q   <= 3'd0;
            rs2_q   <= 3'd0;
            imm_q   <= 16'd0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            busy_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
            busy_q  <= busy_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.if_ready     = ready;
    assign bus.id_valid     = valid_q;
    assign bus.id_pc        = pc_q;
    assign bus.id_op        = op_q;
    assign bus.id_rd        = rd_q;
    assign bus.id_rs1       = rs1_q;
    assign bus.id_rs2       = rs2_q;
    assign bus.id_imm       = imm_q;
    assign bus.id_we        = we_q;
    assign bus.id_illegal   = ill_q;
    assign bus.halt_program = halt_q;
endmodule
